serial_comparator_ctrl: RTL
===========================

Name: serial_comparator_ctrl

Overview:
- Controller that compares two WIDTH-bit unsigned operands by sequencing a single 2-bit magnitude-compare slice across the operands, most-significant pair first, one slice per clock.
- Trades latency for area when wide compares are needed but only 2-bit comparator logic is available.
- Provides a start/busy/done handshake toward the requesting logic.
- Presents registered alb/aeb/agb results that hold until the next accepted start.

Parameters:
- WIDTH, 8, operand width in bits; must be even and at least 2; N = WIDTH/2 slices.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high in COMPARE and DONE states.
- done  output  1  one-cycle pulse; results valid from this cycle.
- alb  output  1  registered result, A < B.
- aeb  output  1  registered result, A == B.
- agb  output  1  registered result, A > B.

Behaviour:
- Reset: rst is sampled on the rising edge of clk (synchronous, active-high).
  - Forces state IDLE, slice index to N-1, and internal decision flags cleared.
  - Forces busy=0, done=0, alb=0, aeb=0, agb=0.
  - rst takes priority over every other input.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 captures a and b into internal registers, clears alb/aeb/agb to 0, sets index=N-1, and moves to COMPARE.
  - start=0 leaves the state in IDLE and holds previous results.
- COMPARE: each cycle evaluates the 2-bit slice a_cap[2i+1:2i] against b_cap[2i+1:2i], where i = index.
  - Slice equal and i>0: decrement index, stay in COMPARE.
  - Slice unequal: latch the lt/gt decision. Whether the controller exits here is set by EARLY_EXIT_EN.
  - i==0: move to DONE. The final decision is the first unequal slice's lt/gt; if no slice differed, the result is equal.
  - Once a slice has differed, later slices must not overwrite the latched decision.
- DONE:
  - Lasts one cycle, then returns to IDLE.
  - done=1 and busy=1.
  - Exactly one of alb/aeb/agb is 1 and is registered.
  - Results hold after DONE until the next accepted start clears them.
- Latency: let start be sampled at edge 0.
  - COMPARE occupies cycles 1..N.
  - done=1 in cycle N+1 (full-length case).
  - The earliest possible start of the next compare is sampled in cycle N+2.
- Handshake:
  - start is ignored while busy=1, including during DONE.
  - a and b may change freely after capture without affecting the in-flight compare.
- Reset mid-operation: the compare is aborted, no done pulse occurs, and all outputs return to 0.
- WIDTH=2 (N=1): one COMPARE cycle; done occurs in cycle 2.

Optional Feature:
- Macro: SERIAL_COMPARATOR_EARLY_EXIT_EN.
- Defined:
  - The first unequal slice moves the controller directly from COMPARE to DONE.
  - If the first mismatch is at slice position k (k=1 is the MSB pair, k=N is the LSB pair), done=1 in cycle k+1.
  - Equal operands still take N+1 cycles.
- Undefined:
  - Always N COMPARE cycles; done=1 in cycle N+1 regardless of data.
  - The decision from the first mismatch is held while the remaining slices are walked.

Test Plan (WIDTH=8, N=4):
- Reset then idle: hold rst=1 for 2 cycles, then start=0 -> busy=0, done=0, alb/aeb/agb=0 throughout.
- Equal operands: a=0x00, b=0x00, start pulse -> done in cycle 5, aeb=1, alb=0, agb=0.
  - Repeat with a=0xFF, b=0xFF -> same timing and result.
- MSB mismatch: a=0x80, b=0x7F -> agb=1.
  - Done in cycle 2 with the macro defined; done in cycle 5 without it.
- LSB mismatch: a=0x12, b=0x13 -> alb=1, done in cycle 5 in both builds.
  - a=0x13, b=0x12 -> agb=1.
- Busy protection and operand isolation: start a=0x40, b=0x40.
  - Pulse start with a=0x00, b=0xFF in cycles 2 and 5, and change a/b in cycle 2 -> second request ignored, aeb=1 in cycle 5.
  - A new start in cycle 6 is accepted.
- Reset mid-compare: start a=0x01, b=0x02, then assert rst in cycle 2 -> no done pulse, outputs 0.
  - The next start with a=0x03, b=0x01 completes normally with agb=1.

Source files
------------

// File: rtl/serial_comparator_if.sv
// Handshake and operand bundle between a requester and serial_comparator_ctrl.
// The master drives start and the operands; the slave returns status and results.
interface serial_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             alb;
    logic             aeb;
    logic             agb;

    modport master (
        output start, a, b,
        input  busy, done, alb, aeb, agb
    );

    modport slave (
        input  start, a, b,
        output busy, done, alb, aeb, agb
    );
endinterface

// File: rtl/serial_comparator_ctrl.sv
// Unsigned WIDTH-bit magnitude compare walked one 2-bit slice per clock, MSB pair first.
// Optional macro SERIAL_COMPARATOR_EARLY_EXIT_EN ends the walk at the first unequal slice.
module serial_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_comparator_if.slave bus
);
    localparam int N     = WIDTH / 2;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N - 1);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
        $error("serial_comparator_ctrl: WIDTH must be even and at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_cap_q, a_cap_d;
    logic [WIDTH-1:0] b_cap_q, b_cap_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             lt_q, lt_d;
    logic             alb_q, alb_d;
    logic             aeb_q, aeb_d;
    logic             agb_q, agb_d;

    logic [1:0] a_slice;
    logic [1:0] b_slice;
    logic       slice_ne;
    logic       slice_lt;
    logic       finish;
    logic       any_ne;
    logic       final_lt;

    assign a_slice  = a_cap_q[{idx_q, 1'b0} +: 2];
    assign b_slice  = b_cap_q[{idx_q, 1'b0} +: 2];
    assign slice_ne = (a_slice != b_slice);
    assign slice_lt = (a_slice < b_slice);

    // The first unequal slice wins; a decision already latched is never overwritten.
    assign any_ne   = decided_q | slice_ne;
    assign final_lt = decided_q ? lt_q : slice_lt;

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    assign finish = slice_ne || (idx_q == '0);
`else
    assign finish = (idx_q == '0);
`endif

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        a_cap_d   = a_cap_q;
        b_cap_d   = b_cap_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        alb_d     = alb_q;
        aeb_d     = aeb_q;
        agb_d     = agb_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_cap_d   = bus.a;
                    b_cap_d   = bus.b;
                    idx_d     = IDX_MSB;
                    decided_d = 1'b0;
                    lt_d      = 1'b0;
                    alb_d     = 1'b0;
                    aeb_d     = 1'b0;
                    agb_d     = 1'b0;
                    state_d   = S_COMPARE;
                end
            end

            S_COMPARE: begin
                if (!decided_q && slice_ne) begin
                    decided_d = 1'b1;
                    lt_d      = slice_lt;
                end
                if (finish) begin
                    alb_d   = any_ne & final_lt;
                    agb_d   = any_ne & ~final_lt;
                    aeb_d   = ~any_ne;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= IDX_MSB;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            alb_q     <= 1'b0;
            aeb_q     <= 1'b0;
            agb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            alb_q     <= alb_d;
            aeb_q     <= aeb_d;
            agb_q     <= agb_d;
        end
    end

    // NOTE: operand capture registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        a_cap_q <= a_cap_d;
        b_cap_q <= b_cap_d;
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.alb  = alb_q;
    assign bus.aeb  = aeb_q;
    assign bus.agb  = agb_q;
endmodule
